// File: rtl/fifo_fwft_pkg.sv
// Shared types and widths for the FWFT read-side output stage.
package fifo_fwft_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  localparam int BUF_CNT_WID   = 2;
  localparam int STALL_CNT_WID = 32;

  function automatic logic [BUF_CNT_WID-1:0] state_to_cnt(input state_e s);
    logic [BUF_CNT_WID-1:0] c;
    c = '0;
    case (s)
      ST_ONE:  c = 2'd1;
      ST_TWO:  c = 2'd2;
      default: c = 2'd0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/fifo_fwft_out_stage.sv
// FWFT output stage for a 1-cycle-read FIFO: read issued in N, out_vld in N+2; head+skid buffer, reads only issued with a guaranteed slot.
// Optional stall counter port under FIFO_FWFT_OUT_STALL_CNT_EN.
module fifo_fwft_out_stage
  import fifo_fwft_pkg::*;
#(
  parameter int DAT_WID   = 32,
  parameter int BUF_DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     fifo_empty,
  output logic                     fifo_oen,
  input  logic [DAT_WID-1:0]       fifo_rdata,
  output logic                     out_vld,
  output logic [DAT_WID-1:0]       out_dat,
  input  logic                     out_rdy,
  output logic [BUF_CNT_WID-1:0]   buf_cnt
`ifdef FIFO_FWFT_OUT_STALL_CNT_EN
  ,
  output logic [STALL_CNT_WID-1:0] stall_cnt
`endif
);

  localparam bit DEPTH_OK = (BUF_DEPTH == 2);

  generate
    if (!DEPTH_OK) begin : g_bad_depth
      $error("fifo_fwft_out_stage: BUF_DEPTH must be 2");
    end
  endgenerate

  state_e               state_q, state_d;
  logic                 inflight_q, inflight_d;
  logic [DAT_WID-1:0]   head_q, head_d;
  logic [DAT_WID-1:0]   skid_q, skid_d;
  logic                 pop;
  logic                 arrival;
  logic [2:0]           occ;

  assign pop     = out_vld & out_rdy;
  assign arrival = inflight_q;

  // Occupancy the buffer will have when a read issued now returns.
  assign occ        = {1'b0, buf_cnt} + {2'b00, inflight_q} - {2'b00, pop};
  assign fifo_oen   = rst_n & ~fifo_empty & (occ < 3'd2);
  assign inflight_d = fifo_oen;

  assign out_vld = (state_q != ST_EMPTY);
  assign out_dat = head_q;
  assign buf_cnt = state_to_cnt(state_q);

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (arrival) begin
          head_d  = fifo_rdata;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (arrival && pop) begin
          head_d = fifo_rdata;
        end else if (arrival) begin
          skid_d  = fifo_rdata;
          state_d = ST_TWO;
        end else if (pop) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (pop) begin
          head_d  = skid_q;
          state_d = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      inflight_q <= 1'b0;
      head_q     <= '0;
      skid_q     <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= inflight_d;
      head_q     <= head_d;
      skid_q     <= skid_d;
    end
  end

  // A word landing while both entries are full would be lost.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !((state_q == ST_TWO) && arrival));

`ifdef FIFO_FWFT_OUT_STALL_CNT_EN
  logic [STALL_CNT_WID-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_vld && !out_rdy && (stall_cnt_q != {STALL_CNT_WID{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_fwft_out_stage.sv
// Bench for fifo_fwft_out_stage with a behavioural 1-cycle-read FIFO alongside it.
module tb_fifo_fwft_out_stage;

  logic        clk;
  logic        rst_n;
  logic        fifo_empty;
  logic        fifo_oen;
  logic [31:0] fifo_rdata;
  logic        out_vld;
  logic [31:0] out_dat;
  logic        out_rdy;
  logic [1:0]  buf_cnt;
`ifdef FIFO_FWFT_OUT_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  fifo_fwft_out_stage #(.DAT_WID(32), .BUF_DEPTH(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fifo_empty (fifo_empty),
    .fifo_oen   (fifo_oen),
    .fifo_rdata (fifo_rdata),
    .out_vld    (out_vld),
    .out_dat    (out_dat),
    .out_rdy    (out_rdy),
    .buf_cnt    (buf_cnt)
`ifdef FIFO_FWFT_OUT_STALL_CNT_EN
    ,
    .stall_cnt  (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural FIFO: words queued in pend enter storage at the next edge.
  logic [31:0] mq[$];
  logic [31:0] pend[$];
  int          fifo_n;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      pend.delete();
      fifo_n     <= 0;
      fifo_rdata <= '0;
    end else begin
      if (fifo_oen && mq.size() > 0) fifo_rdata <= mq.pop_front();
      while (pend.size() > 0) mq.push_back(pend.pop_front());
      fifo_n <= mq.size();
    end
  end

  assign fifo_empty = (fifo_n == 0);

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_q[$];
  bit          mon_en  = 0;
  int          rx_cnt, cnt_ovf, vld_cycles, oen_cycles, vld_rise;
  bit          vld_prev;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic enq(input logic [31:0] d);
    pend.push_back(d);
    exp_q.push_back(d);
  endtask

  task automatic clear_stats();
    rx_cnt = 0; cnt_ovf = 0; vld_cycles = 0; oen_cycles = 0; vld_rise = 0; vld_prev = 0;
  endtask

  // One clock: observe at the falling edge, return 1 time unit after the rising edge.
  task automatic step();
    @(negedge clk);
    if (mon_en && out_vld && out_rdy) begin
      if (exp_q.size() == 0) begin
        check("unexpected_word", out_dat, 32'hxxxx_xxxx);
      end else begin
        check("order", out_dat, exp_q.pop_front());
        rx_cnt++;
      end
    end
    if (buf_cnt > 2'd2) cnt_ovf++;
    if (out_vld) vld_cycles++;
    if (out_vld && !vld_prev) vld_rise++;
    vld_prev = out_vld;
    if (fifo_oen) oen_cycles++;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        push;
    logic [31:0] dat;
    logic        rdy;
    logic        e_vld;
    logic [31:0] e_dat;
    logic        e_oen;
    logic [1:0]  e_cnt;
  } vec_t;

  vec_t tv[6];

  initial begin
    int budget;

    // Single word through an empty FIFO with out_rdy held high.
    tv[0] = '{1'b1, 32'hA5A5_0001, 1'b1, 1'b0, 32'h0,         1'b0, 2'd0};
    tv[1] = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b1, 2'd0};
    tv[2] = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b0, 2'd0};
    tv[3] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'hA5A5_0001, 1'b0, 2'd1};
    tv[4] = '{1'b0, 32'h0,         1'b1, 1'b0, 32'hA5A5_0001, 1'b0, 2'd0};
    tv[5] = '{1'b0, 32'h0,         1'b1, 1'b0, 32'hA5A5_0001, 1'b0, 2'd0};

    rst_n   = 1'b0;
    out_rdy = 1'b0;
    clear_stats();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_vld", 32'(out_vld), 32'd0);
    check("rst_oen", 32'(fifo_oen), 32'd0);
    check("rst_cnt", 32'(buf_cnt), 32'd0);
    check("rst_dat", out_dat, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      if (tv[i].push) pend.push_back(tv[i].dat);
      out_rdy = tv[i].rdy;
      @(negedge clk);
      check($sformatf("vec%0d_vld", i), 32'(out_vld), 32'(tv[i].e_vld));
      check($sformatf("vec%0d_oen", i), 32'(fifo_oen), 32'(tv[i].e_oen));
      check($sformatf("vec%0d_cnt", i), 32'(buf_cnt), 32'(tv[i].e_cnt));
      if (tv[i].e_vld) check($sformatf("vec%0d_dat", i), out_dat, tv[i].e_dat);
      @(posedge clk);
      #1;
    end

    // Backpressure: 8 words, out_rdy low, then release.
    clear_stats();
    mon_en  = 1;
    out_rdy = 1'b0;
    for (int i = 0; i < 8; i++) enq(32'hB000_0000 + i);
    repeat (6) step();
    @(negedge clk);
    check("bp_cnt", 32'(buf_cnt), 32'd2);
    check("bp_oen", 32'(fifo_oen), 32'd0);
    check("bp_vld", 32'(out_vld), 32'd1);
    check("bp_head", out_dat, 32'hB000_0000);
    check("bp_fifo_left", fifo_n, 32'd6);
    @(posedge clk);
    #1;
    out_rdy = 1'b1;
    budget  = 0;
    while (rx_cnt < 8 && budget < 60) begin step(); budget++; end
    check("bp_rx", rx_cnt, 32'd8);

    // Streaming: 16 words preloaded, out_rdy high throughout.
    repeat (3) step();
    clear_stats();
    for (int i = 0; i < 16; i++) enq(i);
    repeat (30) step();
    check("st_rx", rx_cnt, 32'd16);
    check("st_vld_cycles", vld_cycles, 32'd16);
    check("st_vld_runs", vld_rise, 32'd1);
    check("st_oen_cycles", oen_cycles, 32'd16);

    // Random pushes and random out_rdy, 1000 words.
    clear_stats();
    begin
      int pushed;
      pushed = 0;
      budget = 0;
      while (rx_cnt < 1000 && budget < 20000) begin
        out_rdy = 1'($urandom_range(0, 1));
        if (pushed < 1000 && $urandom_range(0, 1) == 1) begin
          enq(32'h1000_0000 + pushed);
          pushed++;
        end
        step();
        budget++;
      end
    end
    check("rnd_rx", rx_cnt, 32'd1000);
    check("rnd_cnt_ovf", cnt_ovf, 32'd0);
    check("rnd_leftover", exp_q.size(), 32'd0);

    // Reset with both entries full and the FIFO still holding data.
    out_rdy = 1'b0;
    repeat (3) step();
    clear_stats();
    for (int i = 0; i < 4; i++) enq(32'hC000_0000 + i);
    repeat (6) step();
    check("mr_pre_cnt", 32'(buf_cnt), 32'd2);
    rst_n = 1'b0;
    #1;
    check("mr_vld", 32'(out_vld), 32'd0);
    check("mr_oen", 32'(fifo_oen), 32'd0);
    check("mr_cnt", 32'(buf_cnt), 32'd0);
    exp_q.delete();
    step();
    rst_n   = 1'b1;
    out_rdy = 1'b1;
    for (int i = 0; i < 3; i++) enq(32'hD000_0000 + i);
    budget = 0;
    while (rx_cnt < 3 && budget < 40) begin step(); budget++; end
    check("mr_rx", rx_cnt, 32'd3);
    repeat (3) step();
    check("mr_extra", rx_cnt, 32'd3);

`ifdef FIFO_FWFT_OUT_STALL_CNT_EN
    rst_n   = 1'b0;
    out_rdy = 1'b0;
    mon_en  = 0;
    step();
    rst_n = 1'b1;
    check("sc_rst", stall_cnt, 32'd0);
    enq(32'hE000_0000);
    exp_q.delete();
    budget = 0;
    while (!out_vld && budget < 10) begin step(); budget++; end
    check("sc_vld", 32'(out_vld), 32'd1);
    repeat (10) step();
    check("sc_ten", stall_cnt, 32'd10);
    force dut.stall_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cnt_q;
    repeat (3) step();
    check("sc_sat", stall_cnt, 32'hFFFF_FFFF);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
